// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore sequencer plus ALU-op and immediate decoders
// feeding the shared-memory multicycle datapath.
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic       w_legal;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic [1:0] w_aluop;

  // Instruction legality, only meaningful while in DECODE
  always_comb begin
    w_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_JAL: w_legal = 1'b1;
      OP_R, OP_I:           w_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                                      (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_BEQ:               w_legal = (funct3 == 3'b000);
      default:              w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECUTER;
            OP_I:         w_next = S_EXECUTEI;
            OP_BEQ:       w_next = S_BEQ;
            OP_JAL:       w_next = S_JAL;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Moore decode of the current state
  always_comb begin
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_aluop    = ALUOP_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    Illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite  = 1'b1;
        w_pcupdate = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        Illegal = ~w_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        w_aluop = ALUOP_FN;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = ALUOP_FN;
      end
      S_ALUWB:    w_regwrite = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pcupdate = 1'b1;
      end
      S_HALT:     Illegal = 1'b1;
      default:    Illegal = 1'b0;
    endcase
  end

  // Reset masks every architectural write enable so an aborted instruction leaves no trace
  assign PCWrite  = ~reset & (w_pcupdate | (w_branch & Zero));
  assign IRWrite  = ~reset & w_irwrite;
  assign RegWrite = ~reset & w_regwrite;
  assign MemWrite = ~reset & w_memwrite;
  assign State    = r_state;

  // ALU-op decoder; op[5] separates register SUB from addi with a set imm bit
  always_comb begin
    ALUControl = ALU_ADD;
    case (w_aluop)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default:   ALUControl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: one trapping and one skipping instance driven in lockstep,
// checked every cycle against an instruction-path reference model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite, t_Illegal;
  logic [1:0] t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ImmSrc;
  logic [2:0] t_ALUControl;
  logic [3:0] t_State;
  logic       s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_RegWrite, s_Illegal;
  logic [1:0] s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ImmSrc;
  logic [2:0] s_ALUControl;
  logic [3:0] s_State;

  always #5 clk = ~clk;

  mc_controller #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite),
    .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
    .ALUControl(t_ALUControl), .ImmSrc(t_ImmSrc), .RegWrite(t_RegWrite),
    .Illegal(t_Illegal), .State(t_State)
  );

  mc_controller #(.ILLEGAL_TRAP(1'b0)) u_skip (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(s_PCWrite), .AdrSrc(s_AdrSrc), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
    .ALUControl(s_ALUControl), .ImmSrc(s_ImmSrc), .RegWrite(s_RegWrite),
    .Illegal(s_Illegal), .State(s_State)
  );

  logic [20:0] act_t, act_s;
  assign act_t = {t_State, t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_ResultSrc,
                  t_ALUSrcA, t_ALUSrcB, t_ALUControl, t_ImmSrc, t_RegWrite, t_Illegal};
  assign act_s = {s_State, s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_ResultSrc,
                  s_ALUSrcA, s_ALUSrcB, s_ALUControl, s_ImmSrc, s_RegWrite, s_Illegal};

  int checks = 0;
  int failures = 0;

  // Reference model: remaining state path of the instruction in flight, per instance
  int path [2][8];
  int plen [2];
  int pidx [2];
  bit halted [2];
  int cur [2];

  logic [3:0] obs_state;
  logic [2:0] obs_alu;
  logic       obs_pcw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f);
    case (o)
      7'b0000011, 7'b0100011, 7'b1101111: return 1'b1;
      7'b0110011, 7'b0010011: return f inside {3'd0, 3'd2, 3'd6, 3'd7};
      7'b1100011: return f == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from FETCH through the last state of a legal instruction
  function automatic int legal_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b1100011: return 3;
      default:    return 4;
    endcase
  endfunction

  task automatic fill_path(input int d, input bit trap);
    path[d][0] = 0;
    path[d][1] = 1;
    plen[d] = 2;
    pidx[d] = 0;
    if (is_legal(op, funct3)) begin
      case (op)
        7'b0000011: begin path[d][2] = 2; path[d][3] = 3; path[d][4] = 4; plen[d] = 5; end
        7'b0100011: begin path[d][2] = 2; path[d][3] = 5; plen[d] = 4; end
        7'b0110011: begin path[d][2] = 6; path[d][3] = 8; plen[d] = 4; end
        7'b0010011: begin path[d][2] = 7; path[d][3] = 8; plen[d] = 4; end
        7'b1100011: begin path[d][2] = 9; plen[d] = 3; end
        default:    begin path[d][2] = 10; path[d][3] = 8; plen[d] = 4; end
      endcase
    end else if (trap) begin
      path[d][2] = 11;
      plen[d] = 3;
    end
  endtask

  function automatic logic [20:0] exp_out(input int s, input logic [6:0] o, input logic [2:0] f,
                                          input logic f7, input logic z, input logic rst);
    logic pcu, br, adr, mw, irw, rw, ill, pcw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'b000;
    case (s)
      0:  begin irw = 1; pcu = 1; sb = 2'd2; rs = 2'd2; end
      1:  begin sa = 2'd1; sb = 2'd1; ill = !is_legal(o, f); end
      2:  begin sa = 2'd2; sb = 2'd1; end
      3:  adr = 1;
      4:  begin rs = 2'd1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6, 7: begin
        sa = 2'd2;
        sb = (s == 7) ? 2'd1 : 2'd0;
        case (f)
          3'd0:    alu = (o[5] && f7) ? 3'b001 : 3'b000;
          3'd2:    alu = 3'b101;
          3'd6:    alu = 3'b011;
          3'd7:    alu = 3'b010;
          default: alu = 3'b000;
        endcase
      end
      8:  rw = 1;
      9:  begin sa = 2'd2; alu = 3'b001; br = 1; end
      10: begin sa = 2'd1; sb = 2'd2; pcu = 1; end
      11: ill = 1;
      default: ill = 0;
    endcase
    pcw = pcu | (br & z);
    if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 : (o == 7'b1101111) ? 2'd3 : 2'd0;
    return {4'(s), pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!halted[d] && pidx[d] >= plen[d]) fill_path(d, d == 1);
      cur[d] = halted[d] ? 11 : path[d][pidx[d]];
    end
    chk("cycle_skip", 32'(act_s), 32'(exp_out(cur[0], op, funct3, funct7b5, Zero, reset)));
    chk("cycle_trap", 32'(act_t), 32'(exp_out(cur[1], op, funct3, funct7b5, Zero, reset)));
    obs_state = t_State;
    obs_alu   = t_ALUControl;
    obs_pcw   = t_PCWrite;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        halted[d] = 0; plen[d] = 0; pidx[d] = 0;
      end else if (!halted[d]) begin
        if (cur[d] == 11) halted[d] = 1;
        else pidx[d]++;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z);
    op = o; funct3 = f; funct7b5 = f7; Zero = z;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         cyc;
    logic [2:0] alu;   // ALUControl seen in execute/branch state, 111 if none
    logic       bpcw;  // PCWrite seen in BEQ
  } vec_t;

  vec_t vt[12];

  initial begin
    int cyc;
    bit done;
    logic [2:0] ex_alu;
    logic       br_pcw;

    vt[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0};
    vt[1]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0};
    vt[2]  = '{7'b0110011, 3'b110, 1'b1, 1'b1, 4, 3'b011, 1'b0};
    vt[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0};
    vt[4]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0};
    vt[5]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0};
    vt[6]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b111, 1'b0};
    vt[7]  = '{7'b0100011, 3'b010, 1'b0, 1'b1, 4, 3'b111, 1'b0};
    vt[8]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1};
    vt[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0};
    vt[10] = '{7'b1101111, 3'b000, 1'b0, 1'b1, 4, 3'b111, 1'b0};
    vt[11] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0};

    for (int d = 0; d < 2; d++) begin halted[d] = 0; plen[d] = 0; pidx[d] = 0; end
    reset = 1'b1;
    set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_state", 32'(t_State), 32'd0);
    chk("rst_enables", 32'({t_PCWrite, t_IRWrite, t_RegWrite, t_MemWrite}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", 32'({t_IRWrite, t_PCWrite, t_ALUSrcB, t_ALUControl}), 32'b1110000);

    // Table of legal instructions
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z);
      ex_alu = 3'b111;
      br_pcw = 1'b0;
      cyc = 0;
      done = 0;
      while (!done && cyc < 12) begin
        tick();
        cyc++;
        if (obs_state inside {4'd6, 4'd7, 4'd9}) ex_alu = obs_alu;
        if (obs_state == 4'd9) br_pcw = obs_pcw;
        if (t_State == 4'd0) done = 1;
      end
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
      chk($sformatf("vec%0d_alu", i), 32'(ex_alu), 32'(vt[i].alu));
      chk($sformatf("vec%0d_brpcw", i), 32'(br_pcw), 32'(vt[i].bpcw));
    end

    // Illegal opcode: trapping instance halts, skipping instance keeps refetching
    set_in(7'b1111111, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    chk("halt_state", 32'(t_State), 32'd11);
    chk("halt_illegal", 32'(t_Illegal), 32'd1);
    chk("halt_enables", 32'({t_PCWrite, t_IRWrite, t_RegWrite, t_MemWrite}), 32'd0);
    chk("skip_state", 32'(s_State), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset_state", 32'(t_State), 32'd0);

    // Reset during lw writeback
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("lw_wb_state", 32'(t_State), 32'd4);
    reset = 1'b1;
    #1;
    chk("lw_wb_regwrite_rst", 32'({t_RegWrite, s_RegWrite}), 32'd0);
    tick();
    reset = 1'b0;
    chk("lw_wb_abort_state", 32'(t_State), 32'd0);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [6:0] o;
      int sel;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: o = 7'($urandom);
      endcase
      set_in(o, 3'($urandom), 1'($urandom), 1'($urandom));
      if (is_legal(op, funct3)) begin
        for (int i = 0; i < legal_len(op); i++) tick();
      end else begin
        for (int i = 0; i < 2 + int'($urandom_range(0, 3)); i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
